// File: rtl/uart_debug_feeder.sv
// uart_debug_feeder: buffers 16-bit debug words in a small FIFO and paces them
// into the debug UART transmitter. The transmitter has no ready output, so the
// feeder times each frame itself and only issues a start once the previous
// frame plus the idle gap has fully elapsed.
module uart_debug_feeder #(
  parameter int DEPTH      = 16,
  parameter int BAUD_DIV   = 434,
  parameter int FRAME_BITS = 18,
  parameter int GAP_BITS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic                     in_ready,
  input  logic                     clr_ovf,
  output logic [15:0]              tx_data,
  output logic                     tx_start,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int FRAME_CYCLES = (FRAME_BITS + GAP_BITS) * BAUD_DIV;
  localparam int TW           = $clog2(FRAME_CYCLES);
  localparam int AW           = $clog2(DEPTH);
  localparam int LW           = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;

  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The head is consumed at the end of the ISSUE cycle; tx_data was already
  // captured from it on the edge that entered ISSUE.
  assign pop      = (state == ISSUE);

  // Word storage; not reset, pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      // A new overflow beats a simultaneous clear.
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
    end
  end

  // Pacing controller: issue one word, then hold off for the rest of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (level != '0) begin
            state    <= ISSUE;
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          // ISSUE itself is one of the frame's cycles, and the timer's zero
          // cycle is another, hence the -2.
          state <= WAIT;
          timer <= TW'(FRAME_CYCLES - 2);
        end
        WAIT: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (level != '0) begin
            state    <= ISSUE;
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_feeder.sv
// Bench for uart_debug_feeder: directed vector table, hand-written corner
// sequences, and a randomized run, all cross-checked every cycle against a
// queue-based model of the pacing rules.
module tb_uart_debug_feeder;

  localparam int DEPTH      = 4;
  localparam int BAUD_DIV   = 4;
  localparam int FRAME_BITS = 18;
  localparam int GAP_BITS   = 1;
  localparam int F          = (FRAME_BITS + GAP_BITS) * BAUD_DIV; // 76

  logic        clk = 1'b0;
  logic        rst, in_valid, clr_ovf;
  logic [15:0] in_data;
  logic        in_ready, tx_start, busy, overflow;
  logic [15:0] tx_data;
  logic [2:0]  level;

  always #5 clk = ~clk;

  uart_debug_feeder #(
    .DEPTH(DEPTH), .BAUD_DIV(BAUD_DIV), .FRAME_BITS(FRAME_BITS), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr_ovf(clr_ovf), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .level(level), .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [15:0] q[$];
  logic        m_start, m_busy, m_ovf;
  logic [15:0] m_data;
  int          last_start;
  bit          have_last;

  // observed starts
  int          st_cyc[$];
  logic [15:0] st_dat[$];

  typedef struct {
    logic        r;
    logic        v;
    logic [15:0] d;
    logic        c;
    logic        e_start;
    logic [15:0] e_data;
    int          e_level;
    logic        e_busy;
    logic        e_ovf;
    logic        e_ready;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rules: a start may occur in a cycle if the FIFO held a word in the previous
  // cycle and at least F cycles have passed since the last start. The issued
  // word leaves the FIFO at the end of its start cycle. Pushes into a full FIFO
  // are dropped and flag overflow.
  task automatic model_step();
    int prev_level;
    bit prev_start;
    if (rst) begin
      q.delete();
      m_start = 0; m_data = '0; m_busy = 0; m_ovf = 0; have_last = 0;
    end else begin
      prev_level = q.size();
      prev_start = m_start;
      if (prev_start) void'(q.pop_front());
      if (in_valid && prev_level == DEPTH) m_ovf = 1;
      else begin
        if (in_valid) q.push_back(in_data);
        if (clr_ovf) m_ovf = 0;
      end
      m_start = (prev_level > 0) && (!have_last || cyc >= last_start + F);
      if (m_start) begin
        m_data     = q[0];
        last_start = cyc;
        have_last  = 1;
      end
      m_busy = have_last && (cyc < last_start + F);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    chk("m_tx_start", tx_start, m_start);
    chk("m_tx_data",  tx_data,  m_data);
    chk("m_busy",     busy,     m_busy);
    chk("m_level",    level,    q.size());
    chk("m_overflow", overflow, m_ovf);
    chk("m_in_ready", in_ready, q.size() != DEPTH);
    if (tx_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(tx_data);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && busy; k++) tick();
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    bit done_pp;
    logic [15:0] exp_ov[6];
    int mode;

    rst = 1; in_valid = 1; in_data = 16'hFFFF; clr_ovf = 0;

    // rst, v, d, clr | start, data, level, busy, ovf, ready
    vt[0] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5C3, 1, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      rst = vt[i].r; in_valid = vt[i].v; in_data = vt[i].d; clr_ovf = vt[i].c;
      tick();
      chk("vec_tx_start", tx_start, vt[i].e_start);
      chk("vec_tx_data",  tx_data,  vt[i].e_data);
      chk("vec_level",    level,    vt[i].e_level);
      chk("vec_busy",     busy,     vt[i].e_busy);
      chk("vec_overflow", overflow, vt[i].e_ovf);
      chk("vec_in_ready", in_ready, vt[i].e_ready);
    end

    // single word: busy spans exactly one frame
    busy_cnt = 2;
    for (int k = 0; k < 200 && busy; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("single_busy_cycles", busy_cnt, 76);
    chk("single_level_end", level, 0);

    // back-to-back words
    st_cyc.delete(); st_dat.delete();
    in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 16'(k);
      tick();
    end
    in_valid = 0;
    for (int k = 0; k < 300 && st_cyc.size() < 3; k++) tick();
    chk("b2b_count", st_cyc.size(), 3);
    if (st_cyc.size() == 3) begin
      chk("b2b_gap1", st_cyc[1] - st_cyc[0], 76);
      chk("b2b_gap2", st_cyc[2] - st_cyc[1], 76);
      for (int k = 0; k < 3; k++) chk("b2b_data", st_dat[k], k + 1);
    end
    wait_idle();

    // overflow, then push during ISSUE with wrapped pointers
    st_cyc.delete(); st_dat.delete();
    in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'h10 + 16'(k);
      tick();
    end
    in_valid = 0;
    chk("ovf_level", level, 4);
    chk("ovf_in_ready", in_ready, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_cleared", overflow, 1'b0);
    done_pp = 0;
    for (int k = 0; k < 600 && st_dat.size() < 6; k++) begin
      tick();
      if (tx_start && st_dat.size() == 4 && !done_pp) begin
        chk("pp_level_issue", level, 2);
        in_valid = 1; in_data = 16'h20;
        tick();
        in_valid = 0;
        chk("pp_level_after", level, 2);
        done_pp = 1;
      end
    end
    exp_ov = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h14, 16'h20};
    chk("ovf_issue_count", st_dat.size(), 6);
    for (int k = 0; k < 6 && k < st_dat.size(); k++) chk("ovf_order", st_dat[k], exp_ov[k]);
    wait_idle();

    // reset mid-frame
    st_cyc.delete(); st_dat.delete();
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'h30 + 16'(k);
      tick();
    end
    in_valid = 0;
    chk("mid_level", level, 3);
    for (int k = 0; k < 100 && st_cyc.size() > 0 && cyc < st_cyc[0] + 30; k++) tick();
    chk("mid_busy_before", busy, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_busy_after", busy, 1'b0);
    chk("mid_level_after", level, 0);
    chk("mid_tx_start_after", tx_start, 1'b0);
    st_cyc.delete(); st_dat.delete();
    for (int k = 0; k < 200; k++) tick();
    chk("mid_no_start", st_cyc.size(), 0);

    // randomized traffic against the model
    mode = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 100 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       in_valid = ($urandom_range(0, 1) == 0);
        1:       in_valid = ($urandom_range(0, 79) == 0);
        default: in_valid = ($urandom_range(0, 9) < 8);
      endcase
      in_data = 16'($urandom);
      clr_ovf = ($urandom_range(0, 30) == 0);
      rst     = ($urandom_range(0, 700) == 0);
      tick();
    end
    rst = 0; in_valid = 0; clr_ovf = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_debug_feeder.md
# uart_debug_feeder

Buffers 16-bit debug words from internal logic in a small FIFO and paces them into the 16-bit debug UART transmitter, one `tx_start` pulse per frame. Sits directly upstream of the debug UART transmitter. That transmitter has no busy/ready output, so this block times each frame itself and never issues a start while a frame is in flight. Producers see a simple valid/ready push interface with overflow flagging.

## Interface
- `DEPTH`, 16: FIFO depth in words; power of two, ≥2.
- `BAUD_DIV`, 434: clocks per UART bit; must equal the transmitter's setting.
- `FRAME_BITS`, 18: bit times per frame (1 start + 16 data + 1 stop).
- `GAP_BITS`, 1: idle bit times inserted between frames.
- Derived `FRAME_CYCLES` = (FRAME_BITS+GAP_BITS)*BAUD_DIV (8246 by default). Timer width is $clog2(FRAME_CYCLES).

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers `in_data` this cycle.
- `in_data`  in  16  debug word.
- `in_ready`  out  1  FIFO not full; a push happens only when `in_valid && in_ready`.
- `clr_ovf`  in  1  clears `overflow`.
- `tx_data`  out  16  word for the transmitter; valid when `tx_start`=1 and held until the next start.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `busy`  out  1  a frame is in flight (pacing timer running).
- `level`  out  $clog2(DEPTH)+1  words currently held in the FIFO.
- `overflow`  out  1  sticky; set when `in_valid` is high while `in_ready` is low.

## Operation
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap naturally, plus an occupancy counter.
  - `in_ready` = (`level` != DEPTH), combinational from registered state.
  - Push and pop in the same cycle leave `level` unchanged.
- No bypass path: a word must be written into the FIFO before it can be issued.
- Controller FSM states:
  - IDLE → ISSUE: when `level` > 0.
  - ISSUE (one cycle):
    - Pop the head into `tx_data`.
    - Drive `tx_start`=1.
    - Load timer with FRAME_CYCLES-2.
    - → WAIT.
  - WAIT: `busy`=1; decrement timer each cycle.
    - When the timer is 0 and `level` > 0: → ISSUE.
    - When the timer is 0 and `level` = 0: → IDLE.
- `busy` is 1 in ISSUE and WAIT, 0 in IDLE.
- Spacing: consecutive `tx_start` pulses are exactly FRAME_CYCLES cycles apart while the FIFO stays non-empty. Spacing is never shorter.
- Overflow:
  - A push attempted while full is dropped and sets `overflow`. FIFO contents are unchanged.
  - If `clr_ovf` and a new overflow occur in the same cycle, set wins.
- Reset, including mid-frame:
  - Values after reset: `level`=0, pointers=0, `tx_start`=0, `tx_data`=0, `busy`=0, `overflow`=0, state IDLE, timer=0.
  - Buffered words are discarded.
  - The transmitter must be reset in the same cycle at top level; the feeder does not track a partially sent frame.

## Timing
- All outputs are registered except `in_ready`.
- Latency: a word pushed at edge N into an empty FIFO while in IDLE gives `tx_start`=1 in the cycle after edge N+1, i.e. 2 edges after the push.
- A word pushed during WAIT is issued at the next ISSUE. A WAIT already in progress is never cut short.
- `tx_start` is never high for two consecutive cycles.
- `level` reflects a push or pop on the edge after it is accepted.

## Test plan
Bench uses `DEPTH`=4, `BAUD_DIV`=4, so FRAME_CYCLES=76.
- **Reset values:** assert `rst` for 3 cycles with `in_valid`=1 → all outputs hold their reset values; `in_ready`=1; no push occurs.
- **Single word:** push 0xA5C3 while IDLE → `tx_start` pulses 2 edges later with `tx_data`=0xA5C3; `busy`=1 for 76 cycles; then IDLE, `level`=0.
- **Back-to-back words:** push 0x0001, 0x0002, 0x0003 on consecutive cycles → three `tx_start` pulses exactly 76 cycles apart, carrying the words in order.
- **Overflow:** hold `in_valid` for 8 cycles with values 0x10 to 0x17 while WAIT blocks issue → FIFO keeps 0x11..0x14 (0x10 was issued first); `in_ready`=0; `overflow`=1. Then pulse `clr_ovf` → `overflow`=0.
- **Simultaneous push and pop:** push in the ISSUE cycle with `level`=2 → `level` stays 2; the pointer wrap across index 3→0 preserves order.
- **Reset mid-frame:** assert `rst` 30 cycles into WAIT with `level`=3 → next cycle `busy`=0, `level`=0; no further `tx_start` until a new push.
